hit_detect: RTL and testbench

Converts a player fire request into per-target hit pulses for the kill counter. On each accepted fire it snapshots the crosshair and the three enemy positions and tests each target against a square hit box. Qualifying targets produce `hit1`/`hit2`/`hit3` pulses on separate cycles, so a counter that adds at most one kill per cycle never loses a simultaneous kill. A cooldown counter then rate-limits firing.

---
 rtl/hit_detect_if.sv | 38 +++
 rtl/hit_detect.sv | 170 +++++++++++++++++
 tb/tb_hit_detect.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hit_detect_if.sv
// hit_detect port bundle: fire request and positions in, kill/miss pulses and busy out.
// master drives the request side, slave is the detector.
interface hit_detect_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10
);
    logic               fire;
    logic [X_WIDTH-1:0] cross_x;
    logic [Y_WIDTH-1:0] cross_y;
    logic [X_WIDTH-1:0] tgt1_x;
    logic [X_WIDTH-1:0] tgt2_x;
    logic [X_WIDTH-1:0] tgt3_x;
    logic [Y_WIDTH-1:0] tgt1_y;
    logic [Y_WIDTH-1:0] tgt2_y;
    logic [Y_WIDTH-1:0] tgt3_y;
    logic [2:0]         tgt_alive;
    logic               hit1;
    logic               hit2;
    logic               hit3;
    logic               miss;
    logic               busy;

    modport master (
        output fire, cross_x, cross_y,
        output tgt1_x, tgt2_x, tgt3_x,
        output tgt1_y, tgt2_y, tgt3_y,
        output tgt_alive,
        input  hit1, hit2, hit3, miss, busy
    );

    modport slave (
        input  fire, cross_x, cross_y,
        input  tgt1_x, tgt2_x, tgt3_x,
        input  tgt1_y, tgt2_y, tgt3_y,
        input  tgt_alive,
        output hit1, hit2, hit3, miss, busy
    );
endinterface

// File: rtl/hit_detect.sv
// Fire-to-hit converter: snapshot, per-target hit box test, serialized kill pulses, cooldown.
// Optional HIT_DETECT_FIRE_QUEUE_EN holds one fire request made while busy.
module hit_detect #(
    parameter int X_WIDTH         = 10,
    parameter int Y_WIDTH         = 10,
    parameter int HIT_RADIUS      = 16,
    parameter int COOLDOWN_CYCLES = 1_000_000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic          clk,
    input  logic          rst,
    hit_detect_if.slave   io
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DIST     = 3'd1;
    localparam logic [2:0] CHECK1   = 3'd2;
    localparam logic [2:0] CHECK2   = 3'd3;
    localparam logic [2:0] CHECK3   = 3'd4;
    localparam logic [2:0] COOLDOWN = 3'd5;

    localparam int DW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 1;
    localparam logic [DW-1:0]        RAD     = DW'(HIT_RADIUS);
    localparam logic [CNT_WIDTH-1:0] CD_LOAD = CNT_WIDTH'(COOLDOWN_CYCLES - 1);

    logic [2:0]                state;
    logic [2:0]                state_nxt;
    logic [CNT_WIDTH-1:0]      cnt;
    logic                      take;
    logic                      pend;
    logic                      cd_done;

    logic [X_WIDTH-1:0]        cx_q;
    logic [Y_WIDTH-1:0]        cy_q;
    logic [2:0][X_WIDTH-1:0]   tx_q;
    logic [2:0][Y_WIDTH-1:0]   ty_q;
    logic [2:0]                alive_q;
    logic [2:0][DW-1:0]        dx_q;
    logic [2:0][DW-1:0]        dy_q;
    logic [2:0]                m;
    logic                      any_q;

    logic hit1_q, hit2_q, hit3_q, miss_q, busy_q;

    // Operands are zero-extended so the sign bit of the difference is the MSB.
    function automatic logic [DW-1:0] absd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] d;
        d = a - b;
        return d[DW-1] ? (~d + 1'b1) : d;
    endfunction

`ifdef HIT_DETECT_FIRE_QUEUE_EN
    logic fire_q;
    logic pending;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fire_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            fire_q <= io.fire;
            if (take)
                pending <= 1'b0;
            else if (io.fire && !fire_q && busy_q)
                pending <= 1'b1;
        end
    end

    assign pend = pending;
`else
    assign pend = 1'b0;
`endif

    assign cd_done = (state == COOLDOWN) && (cnt == '0);

    always_comb begin
        take = 1'b0;
        unique case (1'b1)
            state == IDLE: take = io.fire | pend;
            cd_done:       take = io.fire | pend;
            default:       take = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state == IDLE:     state_nxt = take ? DIST : IDLE;
            state == DIST:     state_nxt = CHECK1;
            state == CHECK1:   state_nxt = CHECK2;
            state == CHECK2:   state_nxt = CHECK3;
            state == CHECK3:   state_nxt = COOLDOWN;
            state == COOLDOWN: state_nxt = cd_done ? (take ? DIST : IDLE) : COOLDOWN;
            default:           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m = '0;
        for (int k = 0; k < 3; k++)
            m[k] = alive_q[k] && (dx_q[k] <= RAD) && (dy_q[k] <= RAD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            alive_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            any_q   <= 1'b0;
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            hit3_q  <= 1'b0;
            miss_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
            hit1_q <= 1'b0;
            hit2_q <= 1'b0;
            hit3_q <= 1'b0;
            miss_q <= 1'b0;
            if (take) begin
                cx_q    <= io.cross_x;
                cy_q    <= io.cross_y;
                tx_q    <= {io.tgt3_x, io.tgt2_x, io.tgt1_x};
                ty_q    <= {io.tgt3_y, io.tgt2_y, io.tgt1_y};
                alive_q <= io.tgt_alive;
            end
            unique case (1'b1)
                state == DIST: begin
                    for (int k = 0; k < 3; k++) begin
                        dx_q[k] <= absd(DW'(cx_q), DW'(tx_q[k]));
                        dy_q[k] <= absd(DW'(cy_q), DW'(ty_q[k]));
                    end
                end
                state == CHECK1: begin
                    hit1_q <= m[0];
                    any_q  <= m[0];
                end
                state == CHECK2: begin
                    hit2_q <= m[1];
                    any_q  <= any_q | m[1];
                end
                state == CHECK3: begin
                    hit3_q <= m[2];
                    miss_q <= !(any_q | m[2]);
                    cnt    <= CD_LOAD;
                end
                state == COOLDOWN: begin
                    if (!cd_done)
                        cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io.hit1 = hit1_q;
    assign io.hit2 = hit2_q;
    assign io.hit3 = hit3_q;
    assign io.miss = miss_q;
    assign io.busy = busy_q;

endmodule

// File: tb/tb_hit_detect.sv
// hit_detect bench: directed test-plan cases plus random stimulus against a shot-schedule model.
// Model rule: shot at edge N yields hit1@N+2, hit2@N+3, hit3/miss@N+4, busy until N+4+C.
module tb_hit_detect;

    localparam int XW    = 10;
    localparam int YW    = 10;
    localparam int R     = 16;
    localparam int C     = 8;
    localparam int DEPTH = 8192;
`ifdef HIT_DETECT_FIRE_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hit_detect_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

    hit_detect #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .HIT_RADIUS(R),
        .COOLDOWN_CYCLES(C), .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic [3:0] exp_out [DEPTH];
    int  cyc       = 0;
    int  free_edge = 0;
    bit  bsy       = 0;
    bit  pend      = 0;
    bit  prevf     = 0;
    bit  rising, take, m1, m2, m3;
    int  kills     = 0;
    int  h1cnt     = 0;

    function automatic bit in_box(int cx, int cy, int tx, int ty, bit alive);
        int dx, dy;
        dx = cx - tx; if (dx < 0) dx = -dx;
        dy = cy - ty; if (dy < 0) dy = -dy;
        return alive && dx <= R && dy <= R;
    endfunction

    initial for (int i = 0; i < DEPTH; i++) exp_out[i] = 4'b0;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = cyc; i < DEPTH; i++) exp_out[i] = 4'b0;
            free_edge = 0;
            bsy = 0;
            pend = 0;
            prevf = 0;
        end else begin
            rising = bus.fire && !prevf;
            prevf  = bus.fire;
            take   = (cyc >= free_edge) && (bus.fire || pend);
            if (take) begin
                pend = 0;
                m1 = in_box(bus.cross_x, bus.cross_y, bus.tgt1_x, bus.tgt1_y, bus.tgt_alive[0]);
                m2 = in_box(bus.cross_x, bus.cross_y, bus.tgt2_x, bus.tgt2_y, bus.tgt_alive[1]);
                m3 = in_box(bus.cross_x, bus.cross_y, bus.tgt3_x, bus.tgt3_y, bus.tgt_alive[2]);
                if (cyc + 4 < DEPTH) begin
                    exp_out[cyc+2][0] = m1;
                    exp_out[cyc+3][1] = m2;
                    exp_out[cyc+4][2] = m3;
                    exp_out[cyc+4][3] = !(m1 || m2 || m3);
                end
                free_edge = cyc + 4 + C;
            end else if (QUEUE && rising && bsy) begin
                pend = 1;
            end
            bsy = cyc < free_edge;
        end
        #1;
        if (cyc < DEPTH) begin
            chk("hit1", bus.hit1, exp_out[cyc][0]);
            chk("hit2", bus.hit2, exp_out[cyc][1]);
            chk("hit3", bus.hit3, exp_out[cyc][2]);
            chk("miss", bus.miss, exp_out[cyc][3]);
            chk("busy", bus.busy, bsy);
        end
        kills += int'(bus.hit1) + int'(bus.hit2) + int'(bus.hit3);
        h1cnt += int'(bus.hit1);
        cyc++;
    end

    task automatic set_pos(input int cx, input int cy,
                           input int t1x, input int t1y,
                           input int t2x, input int t2y,
                           input int t3x, input int t3y,
                           input logic [2:0] alive);
        bus.cross_x = XW'(cx);  bus.cross_y = YW'(cy);
        bus.tgt1_x  = XW'(t1x); bus.tgt1_y  = YW'(t1y);
        bus.tgt2_x  = XW'(t2x); bus.tgt2_y  = YW'(t2y);
        bus.tgt3_x  = XW'(t3x); bus.tgt3_y  = YW'(t3y);
        bus.tgt_alive = alive;
    endtask

    task automatic pulse_fire();
        @(negedge clk) bus.fire = 1'b1;
        @(negedge clk) bus.fire = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    function automatic int clip(int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    int k0, h0, cx, cy;

    initial begin
        rst = 1'b0;
        bus.fire = 1'b0;
        set_pos(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // single hit on target 2
        set_pos(100, 100, 600, 600, 110, 92, 900, 20, 3'b111);
        pulse_fire();
        wait_idle();

        // triple overlap
        set_pos(205, 195, 200, 200, 200, 200, 200, 200, 3'b111);
        k0 = kills;
        pulse_fire();
        wait_idle();
        chk("kills3", kills - k0, 3);

        // hit box edges, liveness, no wrap-around
        set_pos(300, 300, 316, 300, 900, 900, 900, 900, 3'b111);
        pulse_fire(); wait_idle();
        set_pos(300, 300, 317, 300, 900, 900, 900, 900, 3'b111);
        pulse_fire(); wait_idle();
        set_pos(300, 300, 300, 284, 900, 900, 900, 900, 3'b111);
        pulse_fire(); wait_idle();
        set_pos(300, 300, 900, 900, 305, 305, 900, 900, 3'b101);
        pulse_fire(); wait_idle();
        set_pos(0, 500, 1023, 500, 900, 900, 900, 100, 3'b111);
        pulse_fire(); wait_idle();

        // held fire: one shot per 4+C cycles
        set_pos(400, 400, 400, 400, 900, 900, 900, 900, 3'b001);
        h0 = h1cnt;
        @(negedge clk) bus.fire = 1'b1;
        repeat (40) @(negedge clk);
        bus.fire = 1'b0;
        wait_idle();
        chk("rate_shots", h1cnt - h0, 4);

        // reset while in CHECK2
        set_pos(50, 50, 50, 50, 50, 50, 50, 50, 3'b111);
        @(negedge clk) bus.fire = 1'b1;
        @(negedge clk) bus.fire = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        chk("rst_busy", bus.busy, 0);
        pulse_fire();
        wait_idle();

        // fire during cooldown
        set_pos(400, 400, 400, 400, 900, 900, 900, 900, 3'b001);
        h0 = h1cnt;
        pulse_fire();
        repeat (6) @(negedge clk);
        pulse_fire();
        wait_idle();
        chk("queue_shots", h1cnt - h0, QUEUE ? 2 : 1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) != 0);
            bus.fire = ($urandom_range(0, 3) == 0);
            cx = $urandom_range(0, 1023);
            cy = $urandom_range(0, 1023);
            set_pos(cx, cy,
                    clip(cx + $urandom_range(0, 40) - 20), clip(cy + $urandom_range(0, 40) - 20),
                    clip(cx + $urandom_range(0, 40) - 20), clip(cy + $urandom_range(0, 40) - 20),
                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                    3'($urandom_range(0, 7)));
        end
        @(negedge clk);
        rst = 1'b1;
        bus.fire = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
